// File: rtl/ex_alu_unit.sv
// Execute-stage ALU: 1-cycle logic/arith ops, iterative shift-add multiply (WIDTH+1 cycles) stalling via in_ready.
// Holds its result while out_ready is low. Define ALU_OVERFLOW_EN to register signed add/sub overflow.
module ex_alu_unit #(
   parameter int WIDTH     = 32,
   parameter int MUL_CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       select,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             busy
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

   localparam logic [2:0] SEL_AND = 3'b000;
   localparam logic [2:0] SEL_OR  = 3'b001;
   localparam logic [2:0] SEL_ADD = 3'b010;
   localparam logic [2:0] SEL_MUL = 3'b011;
   localparam logic [2:0] SEL_SUB = 3'b110;
   localparam logic [2:0] SEL_SLT = 3'b111;
   localparam logic [MUL_CNT_W-1:0] LP_LAST = MUL_CNT_W'(WIDTH-1);

   state_t               r_state;
   state_t               w_next;
   logic [WIDTH-1:0]     r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [WIDTH-1:0]     r_prod;
   logic [MUL_CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0]     r_result;
   logic                 r_zero;
   logic                 r_out_vld;

   logic                 w_out_free;
   logic                 w_accept;
   logic                 w_mul_start;
   logic                 w_mul_last;
   logic                 w_load_sc;
   logic                 w_load_mul;
   logic [WIDTH-1:0]     w_sum;
   logic [WIDTH-1:0]     w_diff;
   logic [WIDTH-1:0]     w_sc_res;

   assign w_out_free  = !r_out_vld || out_ready;
   assign in_ready    = (r_state == S_IDLE) && w_out_free;
   assign w_accept    = in_valid && in_ready;
   assign w_mul_start = w_accept && (select == SEL_MUL);
   assign w_mul_last  = (r_cnt == LP_LAST);
   assign w_load_sc   = w_accept && (select != SEL_MUL);
   assign w_load_mul  = (r_state == S_DONE) && w_out_free;

   assign w_sum  = src_a + src_b;
   assign w_diff = src_a - src_b;

   always_comb begin
      w_sc_res = '0;
      case (select)
         SEL_ADD: w_sc_res = w_sum;
         SEL_SUB: w_sc_res = w_diff;
         SEL_AND: w_sc_res = src_a & src_b;
         SEL_OR:  w_sc_res = src_a | src_b;
         SEL_SLT: w_sc_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         default: w_sc_res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_mul_start) w_next = S_MUL;
         S_MUL:   if (w_mul_last)  w_next = S_DONE;
         S_DONE:  if (w_out_free)  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // One multiplier bit per cycle; the product is final when the FSM reaches DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_prod   <= '0;
         r_cnt    <= '0;
      end else if (w_mul_start) begin
         r_mcand  <= src_a;
         r_mplier <= src_b;
         r_prod   <= '0;
         r_cnt    <= '0;
      end else if (r_state == S_MUL) begin
         if (r_mplier[0]) begin
            r_prod <= r_prod + r_mcand;
         end
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + 1'b1;
      end
   end

   // A load in the same cycle as a drain keeps out_valid high with the new data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result  <= '0;
         r_zero    <= 1'b0;
         r_out_vld <= 1'b0;
      end else if (w_load_sc) begin
         r_result  <= w_sc_res;
         r_zero    <= (w_sc_res == '0);
         r_out_vld <= 1'b1;
      end else if (w_load_mul) begin
         r_result  <= r_prod;
         r_zero    <= (r_prod == '0);
         r_out_vld <= 1'b1;
      end else if (out_ready) begin
         r_out_vld <= 1'b0;
      end
   end

`ifdef ALU_OVERFLOW_EN
   logic w_ovf;
   logic r_ovf;

   always_comb begin
      w_ovf = 1'b0;
      case (select)
         SEL_ADD: w_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (w_sum[WIDTH-1] != src_a[WIDTH-1]);
         SEL_SUB: w_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (w_diff[WIDTH-1] != src_a[WIDTH-1]);
         default: w_ovf = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_load_sc) begin
         r_ovf <= w_ovf;
      end else if (w_load_mul) begin
         r_ovf <= 1'b0;
      end
   end

   assign overflow = r_ovf;
`else
   assign overflow = 1'b0;
`endif

   assign result    = r_result;
   assign zero      = r_zero;
   assign out_valid = r_out_vld;
   assign busy      = (r_state != S_IDLE);

endmodule
